// File: rtl/sparse_idx_loader.sv
// Sparse index loader: assembles 16-bit indices from a byte stream into a
// small buffer, then hands off to the poly-mult core and waits for it.
module sparse_idx_loader #(
    parameter int pW         = 66,
    parameter int pN         = 17669,
    parameter int pIDX_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  go,
    input  logic                  clear,
    output logic                  start,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  full,
    output logic                  err,
    output logic [6:0]            count,
    input  logic [6:0]            idx_rd_addr,
    output logic [pIDX_WIDTH-1:0] idx_rd_data
);

    localparam logic [1:0] LO   = 2'd0;
    localparam logic [1:0] HI   = 2'd1;
    localparam logic [1:0] FULL = 2'd2;
    localparam logic [1:0] RUN  = 2'd3;

    // Bits above the index width must be zero for an index to be legal.
    localparam logic [15:0] HI_MASK = 16'(32'hFFFF << pIDX_WIDTH);
    localparam logic [16:0] N_LIM   = 17'(pN);
    localparam logic [6:0]  W_LIM   = 7'(pW);

    logic [1:0]            state;
    logic [7:0]            low_byte;
    logic [15:0]           idx;
    logic                  legal;
    logic                  xfer;
    logic                  wr_en;
    logic [6:0]            count_inc;
    logic [pIDX_WIDTH-1:0] rd_mux;
    logic [pIDX_WIDTH-1:0] idx_buf [pW];

    assign byte_ready = (state == LO) || (state == HI);
    assign busy       = (state == RUN);
    assign full       = (count == W_LIM);
    assign xfer       = byte_valid && byte_ready;
    assign idx        = {byte_data, low_byte};
    assign legal      = ((idx & HI_MASK) == 16'd0) && ({1'b0, idx} < N_LIM);
    assign wr_en      = (state == HI) && xfer && legal && !clear;
    assign count_inc  = count + 7'd1;

    // Buffer storage is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < pW; i++) begin
            if (wr_en && count == 7'(i)) begin
                idx_buf[i] <= idx[pIDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < pW; i++) begin
            if (idx_rd_addr == 7'(i)) begin
                rd_mux = idx_buf[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LO;
            low_byte    <= 8'd0;
            count       <= 7'd0;
            err         <= 1'b0;
            start       <= 1'b0;
            idx_rd_data <= '0;
        end else begin
            start       <= 1'b0;
            idx_rd_data <= rd_mux;
            if (clear && state != RUN) begin
                state <= LO;
                count <= 7'd0;
                err   <= 1'b0;
            end else begin
                case (state)
                    LO: begin
                        if (xfer) begin
                            low_byte <= byte_data;
                            state    <= HI;
                        end
                    end
                    HI: begin
                        if (xfer) begin
                            if (legal) begin
                                count <= count_inc;
                                state <= (count_inc == W_LIM) ? FULL : LO;
                            end else begin
                                err   <= 1'b1;
                                state <= LO;
                            end
                        end
                    end
                    FULL: begin
                        if (go) begin
                            start <= 1'b1;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (core_done) begin
                            count <= 7'd0;
                            state <= LO;
                        end
                    end
                    default: state <= LO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sparse_idx_loader.sv
// Bench for sparse_idx_loader: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_sparse_idx_loader;

    localparam int W  = 4;
    localparam int N  = 100;
    localparam int IW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          go;
    logic          clear;
    logic          start;
    logic          core_done;
    logic          busy;
    logic          full;
    logic          err;
    logic [6:0]    count;
    logic [6:0]    idx_rd_addr;
    logic [IW-1:0] idx_rd_data;

    int checks = 0;
    int failures = 0;

    // Model: list of stored indices, a pending-low flag, and a running flag.
    int  m_cnt;
    bit  m_err;
    bit  m_have_low;
    int  m_low;
    bit  m_run;
    bit  m_start;
    int  m_buf [W];
    bit  m_valid [W];
    int  m_rd;
    bit  m_rd_known;

    always #5 clk = ~clk;

    sparse_idx_loader #(.pW(W), .pN(N), .pIDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .go(go), .clear(clear),
        .start(start), .core_done(core_done), .busy(busy),
        .full(full), .err(err), .count(count),
        .idx_rd_addr(idx_rd_addr), .idx_rd_data(idx_rd_data)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_err = 0; m_have_low = 0; m_low = 0;
        m_run = 0; m_start = 0; m_rd = 0; m_rd_known = 1;
    endtask

    task automatic model_update();
        int idx;
        if (rst) begin
            model_reset();
            return;
        end
        m_start = 0;
        if (idx_rd_addr >= W) begin
            m_rd = 0; m_rd_known = 1;
        end else begin
            m_rd = m_buf[idx_rd_addr]; m_rd_known = m_valid[idx_rd_addr];
        end
        if (clear && !m_run) begin
            m_cnt = 0; m_err = 0; m_have_low = 0;
        end else if (m_run) begin
            if (core_done) begin
                m_run = 0; m_cnt = 0;
            end
        end else if (m_cnt == W) begin
            if (go) begin
                m_run = 1; m_start = 1;
            end
        end else if (byte_valid) begin
            if (!m_have_low) begin
                m_low = int'(byte_data); m_have_low = 1;
            end else begin
                idx = int'(byte_data) * 256 + m_low;
                m_have_low = 0;
                if (idx < N && idx < (1 << IW)) begin
                    m_buf[m_cnt] = idx; m_valid[m_cnt] = 1; m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("byte_ready", int'(byte_ready), int'(!m_run && m_cnt < W));
        chk("full", int'(full), int'(m_cnt == W));
        chk("busy", int'(busy), int'(m_run));
        chk("start", int'(start), int'(m_start));
        chk("err", int'(err), int'(m_err));
        chk("count", int'(count), m_cnt);
        if (m_rd_known) chk("idx_rd_data", int'(idx_rd_data), m_rd);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        byte_valid = 0; go = 0; clear = 0; core_done = 0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1; byte_data = b;
        step();
        byte_valid = 0;
    endtask

    task automatic send_idx(input int v);
        send(8'(v));
        send(8'(v >> 8));
    endtask

    task automatic rd(input int a, output int v);
        idx_rd_addr = 7'(a);
        step();
        v = int'(idx_rd_data);
    endtask

    task automatic pulse_go();
        go = 1; step(); go = 0;
    endtask

    task automatic pulse_clear();
        clear = 1; step(); clear = 0;
    endtask

    initial begin
        int v;
        int exp4 [4];
        for (int i = 0; i < W; i++) begin
            m_valid[i] = 0; m_buf[i] = 0;
        end
        rst = 1; idle(); byte_data = 0; idx_rd_addr = 0;
        model_reset();
        step(); step();
        chk("rst_ready", int'(byte_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_rd", int'(idx_rd_data), 0);
        rst = 0;
        step();

        // Four legal indices fill the buffer.
        send(8'h05); send(8'h00);
        chk("cnt1", int'(count), 1);
        send(8'h0A); send(8'h00);
        chk("cnt2", int'(count), 2);
        send(8'h14); send(8'h00);
        chk("cnt3", int'(count), 3);
        send(8'h63); send(8'h00);
        chk("cnt4", int'(count), 4);
        chk("full4", int'(full), 1);
        chk("ready_full", int'(byte_ready), 0);
        exp4 = '{5, 10, 20, 99};
        for (int a = 0; a < 4; a++) begin
            rd(a, v);
            chk("rd_full", v, exp4[a]);
        end
        rd(5, v);
        chk("rd_oob", v, 0);

        // Illegal indices set err without storing.
        pulse_clear();
        send(8'h64); send(8'h00);
        chk("err_100", int'(err), 1);
        chk("cnt_100", int'(count), 0);
        send(8'h00); send(8'h80);
        chk("cnt_8000", int'(count), 0);
        send(8'h07); send(8'h00);
        chk("cnt_7", int'(count), 1);
        rd(0, v);
        chk("rd_7", v, 7);

        // Full buffer handoff and completion.
        pulse_clear();
        send_idx(1); send_idx(2); send_idx(3); send_idx(4);
        pulse_go();
        chk("start_hi", int'(start), 1);
        chk("busy_hi", int'(busy), 1);
        step();
        chk("start_once", int'(start), 0);
        for (int i = 0; i < 18; i++) step();
        core_done = 1; step(); core_done = 0;
        chk("done_busy", int'(busy), 0);
        chk("done_cnt", int'(count), 0);
        chk("done_ready", int'(byte_ready), 1);
        rd(2, v);
        chk("persist", v, 3);

        // go with partial count, clear in RUN, clear mid-pair.
        send_idx(11); send_idx(12);
        pulse_go();
        chk("go_partial", int'(start), 0);
        send_idx(13); send_idx(14);
        pulse_go();
        pulse_clear();
        chk("clr_run_busy", int'(busy), 1);
        chk("clr_run_cnt", int'(count), 4);
        core_done = 1; step(); core_done = 0;
        send_idx(21); send_idx(22);
        send(8'h03);
        pulse_clear();
        chk("clr_cnt", int'(count), 0);
        send(8'h09); send(8'h00);
        rd(0, v);
        chk("clr_rd9", v, 9);

        // Asynchronous reset during RUN.
        pulse_clear();
        send_idx(31); send_idx(32); send_idx(33); send_idx(34);
        pulse_go();
        step();
        #2 rst = 1;
        #1;
        model_reset();
        compare();
        chk("arst_busy", int'(busy), 0);
        step();
        rst = 0;
        step();
        core_done = 1; step(); core_done = 0;
        chk("arst_done_busy", int'(busy), 0);
        chk("arst_start", int'(start), 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            byte_valid  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) byte_data = 8'($urandom);
            else if (m_have_low) byte_data = 8'h00;
            else byte_data = 8'($urandom_range(0, 120));
            go          = ($urandom_range(0, 9) == 0);
            clear       = ($urandom_range(0, 39) == 0);
            core_done   = ($urandom_range(0, 14) == 0);
            idx_rd_addr = 7'($urandom_range(0, 7));
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
